pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Interlock/sequencing controller for the 5-stage pipeline: drives the ID/EX operand forward selects,
//  the PC/IF-ID write enable, the ID/EX bubble, the IF/ID flush and the launch/busy sequencing of the multi-cycle MDU.
//  Sits beside the ID stage; observes ID sources and the EX/MEM destination fields held by the pipeline registers.
// PARAMETERS
//  MDU_LAT  32  MDU busy cycles after launch (legal 1..255)
//  CNT_W    8   width of MDU countdown and stall counter
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  clrn          in   1      asynchronous active-low reset
//  drs, drt      in   5      ID source register numbers
//  d_use_rs/rt   in   1      ID instruction really reads rs / rt
//  ewreg,em2reg  in   1      EX stage writes reg / result comes from memory
//  ern           in   5      EX destination reg
//  mwreg,mm2reg  in   1      MEM stage writes reg / is a load
//  mrn           in   5      MEM destination reg
//  d_mdu_start   in   1      ID instruction launches MDU (mult/div)
//  d_mdu_use     in   1      ID instruction reads HI/LO
//  d_br_taken    in   1      ID branch/jump resolved taken
//  fwda, fwdb    out  2      operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
//  wpcir         out  1      1 = PC and IF/ID advance; 0 = hold
//  bubble        out  1      1 = ID/EX loads a nop (dwreg=dwmem=0)
//  flush_ifid    out  1      1 = IF/ID loads a nop on next edge
//  mdu_go        out  1      one-cycle MDU launch strobe
//  mdu_busy      out  1      MDU operation in flight
//  stall_cycles  out  CNT_W  saturating count of cycles with wpcir=0
// BEHAVIOUR
//  - Reset (clrn=0, async): state IDLE, mdu_cnt=0, stall_cycles=0; mdu_busy=0, mdu_go=0 immediately.
//  - Forward (per operand, src=drs/drt, priority top first, dest 0 never matches):
//      ewreg & ~em2reg & ern==src -> 01; mwreg & ~mm2reg & mrn==src -> 10; mwreg & mm2reg & mrn==src -> 11; else 00.
//  - Load-use stall lu = ewreg & em2reg & ern!=0 & ((d_use_rs & ern==drs) | (d_use_rt & ern==drt)).
//  - MDU stall ms = (state==BUSY) & (d_mdu_start | d_mdu_use).
//  - stall = lu | ms; wpcir=~stall; bubble=stall. All of these are combinational, with zero latency.
//  - flush_ifid = d_br_taken & ~stall (a branch held by a stall is not yet resolved).
//  - MDU FSM: IDLE --(d_mdu_start & ~stall)--> BUSY, mdu_go=1 that cycle, mdu_cnt<=MDU_LAT.
//    BUSY: mdu_cnt decrements each edge. At an edge where mdu_cnt==1, state -> IDLE.
//    mdu_busy = (state==BUSY), so it is high for exactly MDU_LAT cycles.
//  - Back-to-back: a start or HI/LO read seen in the last BUSY cycle still stalls, and is accepted the following cycle.
//  - mdu_go never fires while stalled. A start that coincides with lu waits for lu to clear.
//  - stall_cycles increments on each edge with stall=1 and saturates at all-ones.
//  - Reset asserted mid-BUSY aborts the operation: IDLE, counter 0, no mdu_go.
// CONFIGURATION
//  PIPE_FWD_EN defined: forwarding as above.
//  PIPE_FWD_EN undefined: fwda=fwdb=00 always. lu is replaced by raw = any used nonzero source equal to
//    ern (with ewreg) or mrn (with mwreg). stall = raw | ms. All other behaviour is unchanged.
// STRUCTURE
//  pipe_ctrl_defs.vh (shared include): FWD_RF/FWD_EXA/FWD_MEMA/FWD_MEMD encodings, MDU_IDLE/MDU_BUSY state codes.
//  Sub-module pipe_fwd_unit: one operand compare (src, use -> fwd[1:0], hit_e_load, hit_any),
//    instantiated twice (rs, rt).
//  Top module holds the FSM, counters and stall/flush logic.
// TESTING
//  1. ern=5,ewreg=1,em2reg=0,drs=5 -> fwda=01. Then mrn=5,mm2reg=1,ewreg=0 -> fwda=11. Repeat with drs=0 -> fwda=00.
//  2. Load in EX ern=7,em2reg=1, ID drt=7,d_use_rt=1 -> wpcir=0,bubble=1 for 1 cycle, then fwdb=11; stall_cycles=1.
//  3. MDU_LAT=4: start accepted -> mdu_go 1 cycle, mdu_busy 4 cycles. d_mdu_use on next cycle -> stalls 4 cycles.
//  4. d_br_taken=1 with lu=1 -> flush_ifid=0. The next cycle, with lu clear -> flush_ifid=1.
//  5. Drop clrn mid-BUSY (cnt=2) -> mdu_busy=0 asynchronously. After release, a new start launches immediately.
//  6. PIPE_FWD_EN undefined: mrn=3,mwreg=1,drs=3,d_use_rs=1 -> stall=1, fwda=00.
//     Force 300 stall cycles -> stall_cycles saturates at 255.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects and MDU states.
// Build option PIPE_FWD_EN selects operand forwarding; without it every RAW hazard stalls.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EXA  = 2'b01;
    localparam logic [1:0] FWD_MEMA = 2'b10;
    localparam logic [1:0] FWD_MEMD = 2'b11;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

`ifdef PIPE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Per-operand dependency check against the EX and MEM destinations.
// Produces the forward select plus load-use and plain RAW hit flags for the stall logic.
module pipe_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_use,
    input  logic       i_ewreg,
    input  logic       i_em2reg,
    input  logic [4:0] i_ern,
    input  logic       i_mwreg,
    input  logic       i_mm2reg,
    input  logic [4:0] i_mrn,
    output logic [1:0] o_fwd,
    output logic       o_lu_hit,
    output logic       o_raw_hit
);

    logic w_e_hit;
    logic w_m_hit;

    // Register 0 is hard-wired, so a zero destination never produces a dependency.
    assign w_e_hit = i_ewreg && (i_ern != 5'd0) && (i_ern == i_src);
    assign w_m_hit = i_mwreg && (i_mrn != 5'd0) && (i_mrn == i_src);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_e_hit && !i_em2reg) begin
            o_fwd = FWD_EXA;
        end else if (w_m_hit && !i_mm2reg) begin
            o_fwd = FWD_MEMA;
        end else if (w_m_hit && i_mm2reg) begin
            o_fwd = FWD_MEMD;
        end
    end

    assign o_lu_hit  = i_use && w_e_hit && i_em2reg;
    assign o_raw_hit = i_use && (w_e_hit || w_m_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock controller beside ID: forward selects, stall/bubble/flush and MDU launch sequencing.
// Define PIPE_FWD_EN to enable forwarding; otherwise all RAW hazards stall and selects stay at regfile.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    input  logic             d_mdu_start,
    input  logic             d_mdu_use,
    input  logic             d_br_taken,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             bubble,
    output logic             flush_ifid,
    output logic             mdu_go,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    mdu_state_t       r_state;
    mdu_state_t       w_state_next;
    logic [CNT_W-1:0] r_mdu_cnt;
    logic [CNT_W-1:0] w_mdu_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0] w_fwd_rs, w_fwd_rt;
    logic       w_lu_rs, w_lu_rt, w_raw_rs, w_raw_rt;
    logic       w_hz, w_ms, w_stall;

    pipe_fwd_unit u_fwd_rs (
        .i_src    (drs),
        .i_use    (d_use_rs),
        .i_ewreg  (ewreg),
        .i_em2reg (em2reg),
        .i_ern    (ern),
        .i_mwreg  (mwreg),
        .i_mm2reg (mm2reg),
        .i_mrn    (mrn),
        .o_fwd    (w_fwd_rs),
        .o_lu_hit (w_lu_rs),
        .o_raw_hit(w_raw_rs)
    );

    pipe_fwd_unit u_fwd_rt (
        .i_src    (drt),
        .i_use    (d_use_rt),
        .i_ewreg  (ewreg),
        .i_em2reg (em2reg),
        .i_ern    (ern),
        .i_mwreg  (mwreg),
        .i_mm2reg (mm2reg),
        .i_mrn    (mrn),
        .o_fwd    (w_fwd_rt),
        .o_lu_hit (w_lu_rt),
        .o_raw_hit(w_raw_rt)
    );

    // With forwarding only a load in EX must wait; without it any pending write does.
    assign w_hz    = FWD_EN ? (w_lu_rs || w_lu_rt) : (w_raw_rs || w_raw_rt);
    assign w_ms    = (r_state == MDU_BUSY) && (d_mdu_start || d_mdu_use);
    assign w_stall = w_hz || w_ms;

    assign fwda         = FWD_EN ? w_fwd_rs : FWD_RF;
    assign fwdb         = FWD_EN ? w_fwd_rt : FWD_RF;
    assign wpcir        = !w_stall;
    assign bubble       = w_stall;
    assign flush_ifid   = d_br_taken && !w_stall;
    assign mdu_busy     = (r_state == MDU_BUSY);
    assign stall_cycles = r_stall_cnt;

    always_comb begin
        w_state_next   = r_state;
        w_mdu_cnt_next = r_mdu_cnt;
        mdu_go         = 1'b0;
        case (r_state)
            MDU_IDLE: begin
                if (d_mdu_start && !w_stall) begin
                    mdu_go         = 1'b1;
                    w_state_next   = MDU_BUSY;
                    w_mdu_cnt_next = CNT_W'(MDU_LAT);
                end
            end
            MDU_BUSY: begin
                w_mdu_cnt_next = r_mdu_cnt - CNT_W'(1);
                if (r_mdu_cnt == CNT_W'(1)) begin
                    w_state_next = MDU_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= MDU_IDLE;
            r_mdu_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mdu_cnt <= w_mdu_cnt_next;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written MDU/reset/saturation
// sequences and a randomized run against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 8;
    localparam int SAT = 255;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [4:0] drs, drt, ern, mrn;
    logic       d_use_rs, d_use_rt, ewreg, em2reg, mwreg, mm2reg;
    logic       d_mdu_start, d_mdu_use, d_br_taken;
    logic [1:0] fwda, fwdb;
    logic       wpcir, bubble, flush_ifid, mdu_go, mdu_busy;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int m_rem    = 0;   // model: MDU busy cycles still to run
    int m_cnt    = 0;   // model: stall cycle count

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .drs(drs), .drt(drt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .d_mdu_start(d_mdu_start), .d_mdu_use(d_mdu_use), .d_br_taken(d_br_taken),
        .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
        .flush_ifid(flush_ifid), .mdu_go(mdu_go), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
`ifdef PIPE_FWD_EN
        if (src != 0 && ewreg && !em2reg && ern == src) return 2'b01;
        if (src != 0 && mwreg && mrn == src) return mm2reg ? 2'b11 : 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic m_dep(input logic [4:0] src, input logic used);
`ifdef PIPE_FWD_EN
        return used && src != 0 && ewreg && em2reg && ern == src;
`else
        return used && src != 0 && ((ewreg && ern == src) || (mwreg && mrn == src));
`endif
    endfunction

    function automatic logic m_stall();
        return m_dep(drs, d_use_rs) || m_dep(drt, d_use_rt) ||
               (m_rem > 0 && (d_mdu_start || d_mdu_use));
    endfunction

    always @(posedge clk or negedge clrn) begin : model
        logic st;
        if (!clrn) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            st = m_stall();
            if (st && m_cnt < SAT) m_cnt = m_cnt + 1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (d_mdu_start && !st) m_rem = LAT;
        end
    end

    task automatic check_model(input string tag);
        logic st;
        st = m_stall();
        chk({tag, ".fwda"}, fwda, m_fwd(drs));
        chk({tag, ".fwdb"}, fwdb, m_fwd(drt));
        chk({tag, ".wpcir"}, wpcir, !st);
        chk({tag, ".bubble"}, bubble, st);
        chk({tag, ".flush"}, flush_ifid, d_br_taken && !st);
        chk({tag, ".go"}, mdu_go, (m_rem == 0) && d_mdu_start && !st);
        chk({tag, ".busy"}, mdu_busy, m_rem > 0);
        chk({tag, ".stall_cycles"}, stall_cycles, m_cnt);
    endtask

    // ---------------- helpers ----------------
    task automatic clear_inputs();
        drs = 0; drt = 0; ern = 0; mrn = 0;
        d_use_rs = 0; d_use_rt = 0; ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
        d_mdu_start = 0; d_mdu_use = 0; d_br_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        clrn = 1'b0;
        @(negedge clk);
        chk("rst.busy", mdu_busy, 0);
        chk("rst.go", mdu_go, 0);
        chk("rst.stall_cycles", stall_cycles, 0);
        chk("rst.wpcir", wpcir, 1);
        tick();
        clrn = 1'b1;
    endtask

    typedef struct {
        logic [4:0] drs, drt;
        logic urs, urt, ew, em;
        logic [4:0] ern;
        logic mw, mm;
        logic [4:0] mrn;
        logic br;
        logic [1:0] fa, fb;   // selects with forwarding enabled
        logic st_on, st_off, fl_on, fl_off;
    } vec_t;

    vec_t vecs[13];

    initial begin
        //            drs  drt  urs urt ew em ern  mw mm mrn  br   fa    fb   son soff fon foff
        vecs[0]  = '{5'd5, 5'd0, 1,0, 1,0, 5'd5, 0,0, 5'd0, 0, 2'b01,2'b00, 0,1, 0,0};
        vecs[1]  = '{5'd5, 5'd0, 1,0, 0,0, 5'd0, 1,1, 5'd5, 0, 2'b11,2'b00, 0,1, 0,0};
        vecs[2]  = '{5'd0, 5'd0, 1,1, 1,0, 5'd0, 1,1, 5'd0, 0, 2'b00,2'b00, 0,0, 0,0};
        vecs[3]  = '{5'd0, 5'd7, 0,1, 1,1, 5'd7, 0,0, 5'd0, 0, 2'b00,2'b00, 1,1, 0,0};
        vecs[4]  = '{5'd0, 5'd7, 0,0, 1,1, 5'd7, 0,0, 5'd0, 0, 2'b00,2'b00, 0,0, 0,0};
        vecs[5]  = '{5'd9, 5'd9, 1,1, 1,0, 5'd9, 1,0, 5'd9, 0, 2'b01,2'b01, 0,1, 0,0};
        vecs[6]  = '{5'd0, 5'd12,0,1, 0,0, 5'd0, 1,0, 5'd12,0, 2'b00,2'b10, 0,1, 0,0};
        vecs[7]  = '{5'd3, 5'd4, 0,0, 0,0, 5'd0, 0,0, 5'd0, 1, 2'b00,2'b00, 0,0, 1,1};
        vecs[8]  = '{5'd0, 5'd7, 0,1, 1,1, 5'd7, 0,0, 5'd0, 1, 2'b00,2'b00, 1,1, 0,0};
        vecs[9]  = '{5'd0, 5'd12,0,1, 0,0, 5'd0, 1,0, 5'd12,1, 2'b00,2'b10, 0,1, 1,0};
        vecs[10] = '{5'd7, 5'd0, 1,0, 1,1, 5'd7, 1,1, 5'd7, 0, 2'b11,2'b00, 1,1, 0,0};
        vecs[11] = '{5'd0, 5'd6, 0,0, 1,0, 5'd6, 0,0, 5'd0, 0, 2'b00,2'b01, 0,0, 0,0};
        vecs[12] = '{5'd3, 5'd0, 1,0, 0,0, 5'd0, 1,0, 5'd3, 0, 2'b10,2'b00, 0,1, 0,0};

        do_reset();

        // ---- vector table ----
        for (int i = 0; i < 13; i++) begin
            logic [1:0] efa, efb;
            logic est, efl;
            drs = vecs[i].drs; drt = vecs[i].drt;
            d_use_rs = vecs[i].urs; d_use_rt = vecs[i].urt;
            ewreg = vecs[i].ew; em2reg = vecs[i].em; ern = vecs[i].ern;
            mwreg = vecs[i].mw; mm2reg = vecs[i].mm; mrn = vecs[i].mrn;
            d_br_taken = vecs[i].br;
`ifdef PIPE_FWD_EN
            efa = vecs[i].fa; efb = vecs[i].fb; est = vecs[i].st_on; efl = vecs[i].fl_on;
`else
            efa = 2'b00; efb = 2'b00; est = vecs[i].st_off; efl = vecs[i].fl_off;
`endif
            @(negedge clk);
            chk($sformatf("vec%0d.fwda", i), fwda, efa);
            chk($sformatf("vec%0d.fwdb", i), fwdb, efb);
            chk($sformatf("vec%0d.wpcir", i), wpcir, !est);
            chk($sformatf("vec%0d.bubble", i), bubble, est);
            chk($sformatf("vec%0d.flush", i), flush_ifid, efl);
            tick();
        end

        // ---- load-use: one stall, then the load is in MEM ----
        do_reset();
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; d_use_rt = 1;
        @(negedge clk);
        chk("lu.wpcir", wpcir, 0);
        chk("lu.bubble", bubble, 1);
        tick();
        ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 7;
        @(negedge clk);
        chk("lu.stall_cycles", stall_cycles, 1);
`ifdef PIPE_FWD_EN
        chk("lu.fwdb_after", fwdb, 2'b11);
        chk("lu.wpcir_after", wpcir, 1);
`else
        chk("lu.fwdb_after", fwdb, 2'b00);
        chk("lu.wpcir_after", wpcir, 0);
`endif
        tick();

        // ---- MDU launch, HI/LO read stall, back-to-back start ----
        do_reset();
        d_mdu_start = 1;
        @(negedge clk);
        chk("mdu.go", mdu_go, 1);
        chk("mdu.busy0", mdu_busy, 0);
        chk("mdu.wpcir0", wpcir, 1);
        tick();
        d_mdu_start = 0; d_mdu_use = 1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk($sformatf("mdu.use%0d.busy", k), mdu_busy, 1);
            chk($sformatf("mdu.use%0d.wpcir", k), wpcir, 0);
            chk($sformatf("mdu.use%0d.go", k), mdu_go, 0);
            tick();
        end
        @(negedge clk);
        chk("mdu.use_done.busy", mdu_busy, 0);
        chk("mdu.use_done.wpcir", wpcir, 1);
        tick();
        d_mdu_use = 0; d_mdu_start = 1;
        @(negedge clk);
        chk("mdu.b2b.go_first", mdu_go, 1);
        tick();
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk($sformatf("mdu.b2b%0d.go", k), mdu_go, 0);
            chk($sformatf("mdu.b2b%0d.bubble", k), bubble, 1);
            tick();
        end
        @(negedge clk);
        chk("mdu.b2b.go_second", mdu_go, 1);
        chk("mdu.b2b.busy", mdu_busy, 0);
        chk("mdu.stall_cycles", stall_cycles, 8);
        check_model("mdu");
        tick();
        d_mdu_start = 0;
        repeat (LAT + 1) tick();

        // ---- branch held by a load-use stall ----
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; d_use_rt = 1; d_br_taken = 1;
        @(negedge clk);
        chk("br.flush_held", flush_ifid, 0);
        tick();
        ewreg = 0; em2reg = 0; ern = 0; d_use_rt = 0;
        @(negedge clk);
        chk("br.flush_now", flush_ifid, 1);
        tick();
        clear_inputs();

        // ---- reset mid-BUSY ----
        d_mdu_start = 1;
        tick();
        d_mdu_start = 0;
        tick();
        tick();
        #2 clrn = 1'b0;
        #1;
        chk("rstmid.busy", mdu_busy, 0);
        chk("rstmid.go", mdu_go, 0);
        chk("rstmid.stall_cycles", stall_cycles, 0);
        tick();
        clrn = 1'b1;
        d_mdu_start = 1;
        @(negedge clk);
        chk("rstmid.relaunch_go", mdu_go, 1);
        chk("rstmid.relaunch_busy", mdu_busy, 0);
        tick();
        d_mdu_start = 0;
        @(negedge clk);
        chk("rstmid.busy_after", mdu_busy, 1);
        repeat (LAT + 1) tick();

        // ---- stall counter saturation ----
        do_reset();
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; d_use_rt = 1;
        repeat (100) tick();
        @(negedge clk);
        chk("sat.count100", stall_cycles, 100);
        repeat (200) tick();
        @(negedge clk);
        chk("sat.count300", stall_cycles, SAT);
        check_model("sat");
        tick();

        // ---- randomized run against the model ----
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drs = 5'($urandom_range(0, 3)); drt = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
            d_use_rs = 1'($urandom); d_use_rt = 1'($urandom);
            ewreg = 1'($urandom); em2reg = 1'($urandom);
            mwreg = 1'($urandom); mm2reg = 1'($urandom);
            d_mdu_start = ($urandom_range(0, 3) == 0);
            d_mdu_use = ($urandom_range(0, 3) == 0);
            d_br_taken = 1'($urandom);
            @(negedge clk);
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
